// File: rtl/vx_raster_req_switch.sv
// Round-robin merge of NUM_INPUTS raster slice request streams into one queued request channel,
// with a combined end-of-frame done. Optional perf counters: define RASTER_REQ_PERF_EN.
module vx_raster_req_switch #(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_LANES   = 4,
   parameter int STAMP_W     = 64,
   parameter int QUEUE_DEPTH = 4,
   parameter int PERF_W      = 32
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_INPUTS-1:0]                 in_valid,
   input  logic [NUM_INPUTS*NUM_LANES*STAMP_W-1:0] in_stamps,
   input  logic [NUM_INPUTS*NUM_LANES-1:0]       in_mask,
   input  logic [NUM_INPUTS-1:0]                 in_done,
   output logic [NUM_INPUTS-1:0]                 in_ready,
   output logic                                  out_valid,
   output logic [NUM_LANES*STAMP_W-1:0]          out_stamps,
   output logic [NUM_LANES-1:0]                  out_mask,
   output logic                                  out_done,
   input  logic                                  out_ready,
   output logic [PERF_W-1:0]                     perf_stalls,
   output logic [PERF_W-1:0]                     perf_reqs
);

   localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int AW    = $clog2(QUEUE_DEPTH);
   localparam int CW    = $clog2(QUEUE_DEPTH + 1);
   localparam int SW    = NUM_LANES * STAMP_W;
   localparam int EW    = SW + NUM_LANES;

   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      winner;
   logic [PTR_W-1:0]      next_ptr;
   logic [PTR_W-1:0]      idx;
   logic                  found;
   logic [NUM_INPUTS-1:0] req;
   logic [NUM_INPUTS-1:0] grant;
   logic [NUM_INPUTS-1:0] sticky_done;
   logic [EW-1:0]         mem [QUEUE_DEPTH];
   logic [EW-1:0]         head;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  done_ack;
   logic [NUM_LANES-1:0]  win_mask;
   logic [SW-1:0]         win_stamps;

   // Slices that have latched done sit out of arbitration until the frame is acknowledged.
   assign req = in_valid & ~sticky_done;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_INPUTS);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found) grant[winner] = 1'b1;
   end

   assign next_ptr   = (int'(winner) == NUM_INPUTS - 1) ? '0 : winner + 1'b1;
   assign win_mask   = in_mask[int'(winner)*NUM_LANES +: NUM_LANES];
   assign win_stamps = in_stamps[int'(winner)*SW +: SW];

   assign full      = (count == CW'(QUEUE_DEPTH));
   assign in_ready  = grant & {NUM_INPUTS{~full}};
   assign accept    = found & ~full;
   // An accepted request with no live lanes is dropped here rather than queued.
   assign push      = accept & (|win_mask);
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign out_done  = (&sticky_done) & (count == '0) & ~out_valid;
   assign done_ack  = out_done & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         sticky_done <= '0;
      end else begin
         if (accept) rr_ptr <= next_ptr;
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (done_ack) sticky_done <= '0;
         else          sticky_done <= sticky_done | (in_done & ~in_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {win_mask, win_stamps};
   end

   assign head       = mem[rd_ptr];
   assign out_stamps = out_valid ? head[SW-1:0]  : '0;
   assign out_mask   = out_valid ? head[EW-1:SW] : '0;

`ifdef RASTER_REQ_PERF_EN
   logic [PERF_W-1:0] stall_cnt;
   logic [PERF_W-1:0] req_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         req_cnt   <= '0;
      end else begin
         if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1'b1;
         if (pop)                     req_cnt   <= req_cnt + 1'b1;
      end
   end

   assign perf_stalls = stall_cnt;
   assign perf_reqs   = req_cnt;
`else
   assign perf_stalls = '0;
   assign perf_reqs   = '0;
`endif

endmodule

// File: tb/tb_vx_raster_req_switch.sv
// Scoreboard bench for vx_raster_req_switch: arbitration order, queue full/drain, zero-mask drop,
// done combining and handshake, reset mid-frame.
module tb_vx_raster_req_switch;

   localparam int NI = 4;
   localparam int NL = 4;
   localparam int SW = 64;
   localparam int QD = 4;
   localparam int PW = 32;
   localparam int EW = NL + NL*SW;
`ifdef RASTER_REQ_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NI-1:0]         in_valid;
   logic [NI*NL*SW-1:0]   in_stamps;
   logic [NI*NL-1:0]      in_mask;
   logic [NI-1:0]         in_done;
   logic [NI-1:0]         in_ready;
   logic                  out_valid;
   logic [NL*SW-1:0]      out_stamps;
   logic [NL-1:0]         out_mask;
   logic                  out_done;
   logic                  out_ready;
   logic [PW-1:0]         perf_stalls;
   logic [PW-1:0]         perf_reqs;

   logic [EW-1:0] exp_q[$];
   int tests_run;
   int tests_failed;
   int stalls_m;
   int reqs_m;

   vx_raster_req_switch #(
      .NUM_INPUTS(NI), .NUM_LANES(NL), .STAMP_W(SW), .QUEUE_DEPTH(QD), .PERF_W(PW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_stamps(in_stamps), .in_mask(in_mask), .in_done(in_done),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_stamps(out_stamps), .out_mask(out_mask), .out_done(out_done),
      .out_ready(out_ready),
      .perf_stalls(perf_stalls), .perf_reqs(perf_reqs)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic set_req(input int s, input logic [NL-1:0] m);
      in_valid[s]        = 1'b1;
      in_mask[s*NL +: NL] = m;
      for (int l = 0; l < NL; l++) in_stamps[(s*NL + l)*SW +: SW] = {$urandom, $urandom};
   endtask

   // Model step: retire the visible head if consumed, log accepted pushes, cross one edge.
   task automatic advance();
      if (exp_q.size() != 0) begin
         if (out_ready) begin
            exp_q.delete(0);
            reqs_m++;
         end else begin
            stalls_m++;
         end
      end
      for (int i = 0; i < NI; i++)
         if (in_valid[i] && in_ready[i] && in_mask[i*NL +: NL] != '0)
            exp_q.push_back({in_mask[i*NL +: NL], in_stamps[i*NL*SW +: NL*SW]});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0; in_valid = '0; in_done = '0; in_mask = '0; out_ready = 1'b0;
      exp_q.delete();
      stalls_m = 0; reqs_m = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, out_done, in_ready} !== '0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 0", {out_valid, out_done, in_ready});
      end
      tests_run++;
      if ({out_mask, out_stamps, perf_stalls, perf_reqs} !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 0", {out_mask, out_stamps, perf_stalls, perf_reqs});
      end
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      tests_run++;
      if ({out_valid, out_done} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_release: got %b expected 00", {out_valid, out_done});
      end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1;
      set_req(0, 4'hF);
      #1;
      tests_run++;
      if (in_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL single_grant: got %b expected 0001", in_ready);
      end
      advance();
      in_valid = '0;
      #1;
      tests_run++;
      if (out_valid !== 1'(exp_q.size() != 0)) begin
         tests_failed++;
         $display("FAIL single_valid: got %b expected %b", out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
         tests_run++;
         if ({out_mask, out_stamps} !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL single_head: got %h expected %h", {out_mask, out_stamps}, exp_q[0]);
         end
      end
      advance();
      #1;
      tests_run++;
      if ({out_valid, perf_reqs} !== {1'b0, (PERF_ON ? PW'(reqs_m) : PW'(0))}) begin
         tests_failed++;
         $display("FAIL single_after: got valid=%b reqs=%0d expected valid=0 reqs=%0d",
                  out_valid, perf_reqs, PERF_ON ? reqs_m : 0);
      end
   endtask

   task automatic test_rr();
      logic [NI-1:0] exp_g;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         for (int s = 0; s < NI; s++) set_req(s, 4'hF);
         #1;
         exp_g = NI'(1) << (c % NI);
         tests_run++;
         if (in_ready !== exp_g) begin
            tests_failed++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", c, in_ready, exp_g);
         end
         tests_run++;
         if (out_valid !== 1'(exp_q.size() != 0)) begin
            tests_failed++;
            $display("FAIL rr_valid[%0d]: got %b expected %b", c, out_valid, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            tests_run++;
            if ({out_mask, out_stamps} !== exp_q[0]) begin
               tests_failed++;
               $display("FAIL rr_head[%0d]: got %h expected %h", c, {out_mask, out_stamps}, exp_q[0]);
            end
         end
         advance();
      end
      in_valid = '0;
      #1;
      if (exp_q.size() != 0) begin
         tests_run++;
         if ({out_mask, out_stamps} !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL rr_last: got %h expected %h", {out_mask, out_stamps}, exp_q[0]);
         end
      end
      advance();
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rr_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_full();
      logic [NI-1:0] exp_g;
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         set_req(1, NL'(c + 1));
         #1;
         exp_g = (c < QD) ? 4'b0010 : 4'b0000;
         tests_run++;
         if (in_ready !== exp_g) begin
            tests_failed++;
            $display("FAIL full_grant[%0d]: got %b expected %b", c, in_ready, exp_g);
         end
         if (exp_q.size() != 0) begin
            tests_run++;
            if ({out_mask, out_stamps} !== exp_q[0]) begin
               tests_failed++;
               $display("FAIL full_stable[%0d]: got %h expected %h", c, {out_mask, out_stamps}, exp_q[0]);
            end
         end
         advance();
      end
      in_valid  = '0;
      out_ready = 1'b1;
      for (int c = 0; c < QD; c++) begin
         #1;
         tests_run++;
         if (exp_q.size() == 0 || {out_valid, out_mask, out_stamps} !== {1'b1, exp_q[0]}) begin
            tests_failed++;
            $display("FAIL full_pop[%0d]: got %b/%h expected 1/%h", c, out_valid,
                     {out_mask, out_stamps}, (exp_q.size() != 0) ? exp_q[0] : '0);
         end
         advance();
      end
      #1;
      tests_run++;
      if ({out_valid, perf_stalls, perf_reqs} !==
          {1'b0, (PERF_ON ? PW'(stalls_m) : PW'(0)), (PERF_ON ? PW'(reqs_m) : PW'(0))}) begin
         tests_failed++;
         $display("FAIL full_perf: got valid=%b stalls=%0d reqs=%0d expected 0/%0d/%0d", out_valid,
                  perf_stalls, perf_reqs, PERF_ON ? stalls_m : 0, PERF_ON ? reqs_m : 0);
      end
   endtask

   task automatic test_zero_mask();
      do_reset();
      out_ready = 1'b1;
      set_req(0, 4'h0);
      #1;
      tests_run++;
      if (in_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL zmask_grant: got %b expected 0001", in_ready);
      end
      advance();
      in_valid = '0;
      set_req(0, 4'hF);
      set_req(1, 4'hF);
      #1;
      tests_run++;
      if ({out_valid, in_ready} !== 5'b0_0010) begin
         tests_failed++;
         $display("FAIL zmask_next: got valid=%b grant=%b expected 0/0010", out_valid, in_ready);
      end
      advance();
      in_valid = '0;
      #1;
      tests_run++;
      if (exp_q.size() != 1 || {out_mask, out_stamps} !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL zmask_head: got %h expected %h", {out_mask, out_stamps},
                  (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      advance();
   endtask

   task automatic test_done();
      do_reset();
      out_ready = 1'b0;
      set_req(0, 4'hF);
      #1;
      tests_run++;
      if (in_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL done_grant0: got %b expected 0001", in_ready);
      end
      advance();
      in_valid = '0;
      set_req(1, 4'h3);
      #1;
      tests_run++;
      if (in_ready !== 4'b0010) begin
         tests_failed++;
         $display("FAIL done_grant1: got %b expected 0010", in_ready);
      end
      advance();
      in_valid = '0;
      in_done  = 4'hF;
      #1;
      advance();
      in_valid = 4'b0001;
      #1;
      tests_run++;
      if ({in_ready, out_done} !== 5'b0000_0) begin
         tests_failed++;
         $display("FAIL done_excluded: got ready=%b done=%b expected 0000/0", in_ready, out_done);
      end
      advance();
      in_valid  = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests_run++;
         if (exp_q.size() == 0 || {out_done, out_mask, out_stamps} !== {1'b0, exp_q[0]}) begin
            tests_failed++;
            $display("FAIL done_drain[%0d]: got done=%b head=%h expected 0/%h", c, out_done,
                     {out_mask, out_stamps}, (exp_q.size() != 0) ? exp_q[0] : '0);
         end
         advance();
      end
      in_done = '0;
      #1;
      tests_run++;
      if ({out_done, out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL done_fire: got done/valid=%b expected 10", {out_done, out_valid});
      end
      advance();
      #1;
      tests_run++;
      if (out_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_clear: got %b expected 0", out_done);
      end
   endtask

   task automatic test_valid_done();
      int seq[5] = '{3, 0, 1, 3, 0};
      logic [NI-1:0] exp_g;
      do_reset();
      out_ready = 1'b1;
      set_req(2, 4'hF);
      in_done = 4'b0100;
      #1;
      tests_run++;
      if (in_ready !== 4'b0100) begin
         tests_failed++;
         $display("FAIL vd_first: got %b expected 0100", in_ready);
      end
      advance();
      in_valid = '0;
      #1;
      tests_run++;
      if (exp_q.size() != 1 || {out_valid, out_mask, out_stamps} !== {1'b1, exp_q[0]}) begin
         tests_failed++;
         $display("FAIL vd_pushed: got %b/%h expected 1/%h", out_valid, {out_mask, out_stamps},
                  (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      advance();
      for (int c = 0; c < 5; c++) begin
         for (int s = 0; s < NI; s++) set_req(s, 4'hF);
         #1;
         exp_g = NI'(1) << seq[c];
         tests_run++;
         if (in_ready !== exp_g) begin
            tests_failed++;
            $display("FAIL vd_grant[%0d]: got %b expected %b", c, in_ready, exp_g);
         end
         if (exp_q.size() != 0) begin
            tests_run++;
            if ({out_mask, out_stamps} !== exp_q[0]) begin
               tests_failed++;
               $display("FAIL vd_head[%0d]: got %h expected %h", c, {out_mask, out_stamps}, exp_q[0]);
            end
         end
         advance();
      end
      in_valid = '0;
      in_done  = '0;
      #1;
      advance();
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL vd_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         set_req(0, NL'(c + 1));
         #1;
         tests_run++;
         if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_grant[%0d]: got %b expected 0001", c, in_ready);
         end
         advance();
      end
      in_valid = '0;
      in_done  = 4'b0011;
      #1;
      advance();
      #1;
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_queued: got %b expected 1", out_valid);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if ({out_valid, out_done, perf_stalls, perf_reqs} !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset: got valid=%b done=%b stalls=%0d reqs=%0d expected all 0",
                  out_valid, out_done, perf_stalls, perf_reqs);
      end
      exp_q.delete();
      stalls_m = 0; reqs_m = 0;
      in_done  = '0;
      @(posedge clk);
      #1 reset = 1'b1;
      in_done = 4'b1100;
      #1;
      advance();
      advance();
      #1;
      tests_run++;
      if ({out_done, out_valid} !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_sticky_cleared: got done/valid=%b expected 00", {out_done, out_valid});
      end
      in_done = '0;
   endtask

   initial begin
      reset = 1'b0; in_valid = '0; in_done = '0; in_stamps = '0; in_mask = '0; out_ready = 1'b0;
      tests_run = 0; tests_failed = 0; stalls_m = 0; reqs_m = 0;
      test_reset();
      test_single();
      test_rr();
      test_full();
      test_zero_mask();
      test_done();
      test_valid_done();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
